// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared fixed-point constants and saturation limits for the ODE datapath adders.
package fixed_point_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Limits are returned 64 bits wide; callers slice to their own N.
    function automatic logic [63:0] sat_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int n);
        return 64'd1 << (n - 1);
    endfunction
endpackage

// File: rtl/pipelined_cla_addsub_cla_segment.sv
// Combinational W-bit carry-lookahead slice; each carry is a flat sum of g/p products.
module cla_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         c_msb_o
);
    logic [W-1:0] g, p;
    logic [W:0]   c;
    logic         pp, cc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        c    = '0;
        c[0] = c_i;
        pp   = 1'b1;
        cc   = 1'b0;
        for (int i = 0; i < W; i++) begin
            pp = 1'b1;
            cc = 1'b0;
            for (int j = i; j >= 0; j--) begin
                cc = cc | (g[j] & pp);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & c_i);
        end
    end

    assign sum_o   = p ^ c[W-1:0];
    assign cout_o  = c[W];
    assign c_msb_o = c[W-1];
endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined signed add/sub: one CLA segment per register stage, carry rippled stage to stage,
// with valid/ready back-pressure, optional saturation and sign/zero/overflow flags.
module pipelined_cla_addsub
    import fixed_point_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_op,
    input  logic         in_sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_carry,
    output logic         out_overflow,
    output logic         out_negative,
    output logic         out_zero
);
    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;
    localparam logic [63:0] SMAX_W = sat_max(N);
    localparam logic [63:0] SMIN_W = sat_min(N);
    localparam logic [N-1:0] SAT_MAX = SMAX_W[N-1:0];
    localparam logic [N-1:0] SAT_MIN = SMIN_W[N-1:0];

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_cla_addsub: N must be a multiple of STAGES, 1 <= STAGES <= N");
    end

    logic [STAGES-1:0]        vld_pipe, en, vin, cin_st, sat_st, c_pipe, sat_pipe;
    logic [STAGES-1:0][N-1:0] a_st, b_st, s_st, a_pipe, b_pipe, s_pipe;

    logic [N-1:0] res_q;
    logic         carry_q, ovf_q, neg_q, zero_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] seg_sum;
        logic         seg_cout, seg_cmsb;
        logic [N-1:0] s_d;
        logic         v_q, c_q, sat_q;
        logic [N-1:0] a_q, b_q, s_q;

        if (k == 0) begin : g_in
            // Subtract folds into an add of ~B with inverted borrow-in.
            assign vin[k]    = in_valid;
            assign a_st[k]   = in_a;
            assign b_st[k]   = (in_op == OP_SUB) ? ~in_b : in_b;
            assign cin_st[k] = (in_op == OP_SUB) ? ~in_cin : in_cin;
            assign sat_st[k] = in_sat;
            assign s_st[k]   = '0;
        end else begin : g_link
            assign vin[k]    = vld_pipe[k-1];
            assign a_st[k]   = a_pipe[k-1];
            assign b_st[k]   = b_pipe[k-1];
            assign cin_st[k] = c_pipe[k-1];
            assign sat_st[k] = sat_pipe[k-1];
            assign s_st[k]   = s_pipe[k-1];
        end

        // A stage may load when empty or when its occupant moves on this cycle.
        if (k == L) begin : g_en_last
            assign en[k] = !v_q || out_ready;
        end else begin : g_en_mid
            assign en[k] = !v_q || en[k+1];
        end

        cla_segment #(.W(W)) u_seg (
            .a_i    (a_st[k][k*W +: W]),
            .b_i    (b_st[k][k*W +: W]),
            .c_i    (cin_st[k]),
            .sum_o  (seg_sum),
            .cout_o (seg_cout),
            .c_msb_o(seg_cmsb)
        );

        always_comb begin
            s_d             = s_st[k];
            s_d[k*W +: W]   = seg_sum;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     v_q <= 1'b0;
            else if (en[k]) v_q <= vin[k];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                c_q   <= 1'b0;
                sat_q <= 1'b0;
            end else if (en[k] && vin[k]) begin
                a_q   <= a_st[k];
                b_q   <= b_st[k];
                s_q   <= s_d;
                c_q   <= seg_cout;
                sat_q <= sat_st[k];
            end
        end

        assign vld_pipe[k] = v_q;
        assign a_pipe[k]   = a_q;
        assign b_pipe[k]   = b_q;
        assign s_pipe[k]   = s_q;
        assign c_pipe[k]   = c_q;
        assign sat_pipe[k] = sat_q;

        if (k == L) begin : g_out
            logic         ovf, neg;
            logic [N-1:0] res;

            always_comb begin
                ovf = seg_cmsb ^ seg_cout;
                neg = ovf ^ s_d[N-1];
                res = s_d;
                if (sat_st[k] && ovf) res = neg ? SAT_MIN : SAT_MAX;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q   <= '0;
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    neg_q   <= 1'b0;
                    zero_q  <= 1'b0;
                end else if (en[k] && vin[k]) begin
                    res_q   <= res;
                    carry_q <= seg_cout;
                    ovf_q   <= ovf;
                    neg_q   <= neg;
                    zero_q  <= (res == '0);
                end
            end
        end
    end

    assign in_ready     = en[0];
    assign out_valid    = vld_pipe[L];
    assign out_result   = res_q;
    assign out_carry    = carry_q;
    assign out_overflow = ovf_q;
    assign out_negative = neg_q;
    assign out_zero     = zero_q;
endmodule
